// File: rtl/user_img_stats_engine.sv
// Image statistics engine: scans bytes over an OBI manager port, reports min/max/sum
// and publishes the auto threshold (min+max)>>1. Configured via an MMIO OBI subordinate.

package user_img_stats_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module user_img_stats_engine #(
  parameter type         sbr_obi_req_t = user_img_stats_pkg::obi_req_t,
  parameter type         sbr_obi_rsp_t = user_img_stats_pkg::obi_rsp_t,
  parameter type         mgr_obi_req_t = user_img_stats_pkg::obi_req_t,
  parameter type         mgr_obi_rsp_t = user_img_stats_pkg::obi_rsp_t,
  parameter int unsigned MaxSizeW      = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_sbr_req_i,
  output sbr_obi_rsp_t obi_sbr_rsp_o,
  output mgr_obi_req_t obi_mgr_req_o,
  input  mgr_obi_rsp_t obi_mgr_rsp_i,
  output logic [7:0]   threshold_o,
  output logic         threshold_valid_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    FINISH,
    DONE
  } state_e;

  localparam logic [3:0] RegBase   = 4'd0;
  localparam logic [3:0] RegSize   = 4'd1;
  localparam logic [3:0] RegCtrl   = 4'd2;
  localparam logic [3:0] RegStatus = 4'd3;
  localparam logic [3:0] RegResult = 4'd4;
  localparam logic [3:0] RegSum    = 4'd5;

  function automatic logic [7:0] bytes_min(input logic [31:0] w, input logic [2:0] n,
                                           input logic [7:0] cur);
    logic [7:0] m;
    m = cur;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n && w[8*i +: 8] < m) m = w[8*i +: 8];
    end
    return m;
  endfunction

  function automatic logic [7:0] bytes_max(input logic [31:0] w, input logic [2:0] n,
                                           input logic [7:0] cur);
    logic [7:0] m;
    m = cur;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n && w[8*i +: 8] > m) m = w[8*i +: 8];
    end
    return m;
  endfunction

  function automatic logic [9:0] bytes_sum(input logic [31:0] w, input logic [2:0] n);
    logic [9:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n) s = s + {2'b00, w[8*i +: 8]};
    end
    return s;
  endfunction

  state_e state_q, state_d;

  logic [31:0]         base_q;
  logic [MaxSizeW-1:0] size_q;
  logic [31:0]         addr_q;
  logic [MaxSizeW-1:0] remaining_q;
  logic [7:0]          min_q, max_q, threshold_q;
  logic [31:0]         sum_q;
  logic                busy_q, done_q, err_q, size_zero_q, thr_vld_q;
  sbr_obi_rsp_t        sbr_rsp_q;

  logic [3:0]          reg_sel;
  logic                sbr_wr, start;
  logic [31:0]         rdata_d;
  logic [2:0]          nbytes;
  logic [MaxSizeW-1:0] rem_next;
  logic [8:0]          thr_sum;
  logic                unused_inputs;

  assign reg_sel = obi_sbr_req_i.a.addr[5:2];
  assign sbr_wr  = obi_sbr_req_i.req && obi_sbr_req_i.a.we;
  // Only IDLE/DONE are not busy, so a start seen while busy is simply dropped.
  assign start   = sbr_wr && (reg_sel == RegCtrl) && obi_sbr_req_i.a.wdata[0] && !busy_q;

  assign nbytes   = (remaining_q >= MaxSizeW'(4)) ? 3'd4 : remaining_q[2:0];
  assign rem_next = remaining_q - MaxSizeW'(nbytes);
  assign thr_sum  = {1'b0, min_q} + {1'b0, max_q};

  assign threshold_o       = threshold_q;
  assign threshold_valid_o = thr_vld_q;
  assign unused_inputs     = ^{obi_sbr_req_i, obi_mgr_rsp_i};

  always_comb begin
    rdata_d = 32'hDEADBEEF;
    case (reg_sel)
      RegBase:   rdata_d = base_q;
      RegSize:   rdata_d = 32'(size_q);
      RegCtrl:   rdata_d = '0;
      RegStatus: rdata_d = {29'd0, err_q, busy_q, done_q};
      RegResult: rdata_d = {8'h00, threshold_q, max_q, min_q};
      RegSum:    rdata_d = sum_q;
      default:   rdata_d = 32'hDEADBEEF;
    endcase
  end

  always_comb begin
    obi_sbr_rsp_o     = sbr_rsp_q;
    obi_sbr_rsp_o.gnt = obi_sbr_req_i.req;
  end

  // MMIO subordinate: read data is captured in the request cycle, answered one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbr_rsp_q <= '0;
      base_q    <= '0;
      size_q    <= '0;
    end else begin
      sbr_rsp_q.rvalid  <= obi_sbr_req_i.req;
      sbr_rsp_q.r.err   <= 1'b0;
      if (obi_sbr_req_i.req) begin
        sbr_rsp_q.r.rid   <= obi_sbr_req_i.a.aid;
        sbr_rsp_q.r.rdata <= obi_sbr_req_i.a.we ? 32'd0 : rdata_d;
      end
      if (sbr_wr && !busy_q) begin
        if (reg_sel == RegBase) base_q <= {obi_sbr_req_i.a.wdata[31:2], 2'b00};
        if (reg_sel == RegSize) size_q <= obi_sbr_req_i.a.wdata[MaxSizeW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    obi_mgr_req_o = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (size_q != '0) ? REQ : FINISH;
      end
      REQ: begin
        obi_mgr_req_o.req    = 1'b1;
        obi_mgr_req_o.a.addr = addr_q;
        obi_mgr_req_o.a.we   = 1'b0;
        obi_mgr_req_o.a.be   = 4'hF;
        if (obi_mgr_rsp_i.gnt) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (obi_mgr_rsp_i.rvalid) begin
          if (obi_mgr_rsp_i.r.err)   state_d = DONE;
          else if (rem_next != '0)   state_d = REQ;
          else                       state_d = FINISH;
        end
      end
      FINISH:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Scan engine: state register, per-word statistics and result publication
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      min_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      threshold_q <= '0;
      thr_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      size_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      thr_vld_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            addr_q      <= base_q;
            remaining_q <= size_q;
            min_q       <= 8'hFF;
            max_q       <= 8'h00;
            sum_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            size_zero_q <= (size_q == '0);
          end
        end
        WAIT_RSP: begin
          if (obi_mgr_rsp_i.rvalid) begin
            if (obi_mgr_rsp_i.r.err) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              min_q       <= bytes_min(obi_mgr_rsp_i.r.rdata, nbytes, min_q);
              max_q       <= bytes_max(obi_mgr_rsp_i.r.rdata, nbytes, max_q);
              sum_q       <= sum_q + 32'(bytes_sum(obi_mgr_rsp_i.r.rdata, nbytes));
              remaining_q <= rem_next;
              addr_q      <= addr_q + 32'd4;
            end
          end
        end
        FINISH: begin
          if (size_zero_q) begin
            min_q       <= 8'h00;
            max_q       <= 8'h00;
            threshold_q <= 8'h00;
          end else begin
            threshold_q <= thr_sum[8:1];
          end
          thr_vld_q <= 1'b1;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
